wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 64: width of writeback data, equal to the register file data width.
REQ-002 SHALL have parameter LSU_DEPTH, default 2: number of entries in the LSU result buffer.
REQ-003 SHALL have parameter STARVE_MAX, default 4: consecutive LSU grants allowed while EX waits.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port ex_valid  in  1  EX result present.
REQ-007 SHALL have port ex_wen  in  1  EX result writes a register.
REQ-008 SHALL have port ex_rd  in  5  EX destination register.
REQ-009 SHALL have port ex_wdata  in  DATA_W  EX result data.
REQ-010 SHALL have port ex_ready  out  1  EX result accepted this cycle when high with ex_valid.
REQ-011 SHALL have port lsu_valid  in  1  load result present.
REQ-012 SHALL have port lsu_rd  in  5  load destination register.
REQ-013 SHALL have port lsu_wdata  in  DATA_W  load data.
REQ-014 SHALL have port lsu_ready  out  1  LSU buffer can accept.
REQ-015 SHALL have port w_ena  out  1  register-file write enable, registered.
REQ-016 SHALL have port w_addr  out  5  register-file write address, registered.
REQ-017 SHALL have port w_data  out  DATA_W  register-file write data, registered.
REQ-018 SHALL have port busy_mask  out  32  bit n high while a write to xn is buffered or on the output.

Function
REQ-019 SHALL implement the LSU buffer as a LSU_DEPTH-entry FIFO; push on lsu_valid&&lsu_ready; lsu_ready = (count < LSU_DEPTH), independent of same-cycle pop.
REQ-020 SHALL drive ex_ready = force_ex || (count == 0 && !push_this_cycle_irrelevant), i.e. ex_ready = force_ex || count==0, using registered count only.
REQ-021 SHALL select each cycle: if ex_valid&&ex_ready then EX; else if count>0 then pop FIFO head; else no write.
REQ-022 SHALL register the selected result: next cycle w_ena = wen && rd!=0 (LSU entries have wen=1), w_addr = rd, w_data = data; otherwise w_ena=0 with w_addr/w_data held.
REQ-023 SHALL give latency 1 cycle for EX (accept edge to w_ena) and minimum 2 cycles for LSU (push edge, pop edge, w_ena).
REQ-024 SHALL keep starve counter: increment on a FIFO pop while ex_valid=1; clear on EX acceptance or ex_valid=0; force_ex = (counter == STARVE_MAX).
REQ-025 SHALL, with FIFO full and simultaneous pop, deassert lsu_ready for that cycle (no pass-through).
REQ-026 SHALL wrap FIFO pointers modulo LSU_DEPTH; count never exceeds LSU_DEPTH or underflows.
REQ-027 SHALL never write x0: rd==0 results consume a grant but produce w_ena=0.
REQ-028 SHALL compute busy_mask combinationally from valid FIFO entries (rd!=0) OR (w_ena ? 1<<w_addr : 0).

Reset
REQ-029 SHALL, with rst=1 at a clock edge, clear FIFO count/pointers, starve counter, w_ena, w_addr, w_data to 0, discarding buffered entries mid-operation.
REQ-030 SHALL hold ex_ready=0 and lsu_ready=0 while rst=1; busy_mask=0 the cycle after reset.

Structure
REQ-031 SHALL take DATA_W default and the zero-word constant from the shared defines package; no new typedefs.
REQ-032 SHALL instantiate one sub-module, wb_fifo (parameterised DATA_W+5 wide, LSU_DEPTH deep), exposing count and per-entry rd/valid for busy_mask.

Verification
REQ-033 SHALL cover: EX only, ex_rd=5, ex_wdata=0x1234, ex_wen=1 -> next cycle w_ena=1, w_addr=5, w_data=0x1234.
REQ-034 SHALL cover: lsu push rd=7 data=0xAA at cycle 0 -> w_ena=1, w_addr=7 at cycle 2; busy_mask[7]=1 cycles 1-2.
REQ-035 SHALL cover: ex_rd=0 with ex_wen=1 -> w_ena stays 0, busy_mask stays 0.
REQ-036 SHALL cover: LSU pushes 3 back-to-back -> lsu_ready=0 on third cycle when count=2; data order preserved.
REQ-037 SHALL cover: ex_valid held high with LSU streaming continuously -> EX accepted after exactly 4 LSU pops.
REQ-038 SHALL cover: rst asserted with 2 entries buffered -> next cycle count=0, w_ena=0, busy_mask=0, no buffered write appears afterwards.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared defines for the writeback stage: register-file geometry, the zero
// data word and the destination-register mask helper.
package wb_stage_pkg;

  localparam int unsigned DataWDefault = 64;
  localparam int unsigned RegAddrW     = 5;
  localparam int unsigned NumRegs      = 32;

  localparam logic [DataWDefault-1:0] ZeroWord = '0;

  // One-hot mask for a destination register; x0 is never reported busy.
  function automatic logic [NumRegs-1:0] rd_mask(input logic [RegAddrW-1:0] rd);
    logic [NumRegs-1:0] mask;
    mask = '0;
    if (rd != '0) mask[rd] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO for buffered load results. Entries are {data, rd} with rd in
// the low bits so the owner can see which registers are pending.
module wb_fifo
  import wb_stage_pkg::*;
#(
  parameter int unsigned Width = DataWDefault + RegAddrW,
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               push_i,
  input  logic [Width-1:0]                   push_data_i,
  input  logic                               pop_i,
  output logic [Width-1:0]                   head_o,
  output logic [CntW-1:0]                    count_o,
  output logic [Depth-1:0]                   entry_valid_o,
  output logic [Depth-1:0][RegAddrW-1:0]     entry_rd_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Depth-1:0] valid_q, valid_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Guards keep the count inside [0, Depth] even if the owner misbehaves.
  assign do_push = push_i && (count_q != CntW'(Depth));
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = ptr_inc(rd_ptr_q);
    end
    if (do_push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = ptr_inc(wr_ptr_q);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_comb begin
    for (int i = 0; i < Depth; i++) begin
      entry_rd_o[i] = mem_q[i][RegAddrW-1:0];
    end
  end

  assign head_o        = mem_q[rd_ptr_q];
  assign count_o       = count_q;
  assign entry_valid_o = valid_q;

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: arbitrates EX results against buffered load results for the single
// register-file write port, with a starvation limit so EX cannot be blocked forever.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W     = DataWDefault,
  parameter int unsigned LSU_DEPTH  = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_wen,
  input  logic [4:0]        ex_rd,
  input  logic [DATA_W-1:0] ex_wdata,
  output logic              ex_ready,
  input  logic              lsu_valid,
  input  logic [4:0]        lsu_rd,
  input  logic [DATA_W-1:0] lsu_wdata,
  output logic              lsu_ready,
  output logic              w_ena,
  output logic [4:0]        w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic [31:0]       busy_mask
);

  localparam int unsigned EntryW  = DATA_W + RegAddrW;
  localparam int unsigned CntW    = $clog2(LSU_DEPTH + 1);
  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);

  logic [EntryW-1:0]                       fifo_head;
  logic [CntW-1:0]                         fifo_count;
  logic [LSU_DEPTH-1:0]                    entry_valid;
  logic [LSU_DEPTH-1:0][RegAddrW-1:0]      entry_rd;
  logic                                    fifo_empty, force_ex, ex_fire, push, pop;
  logic [StarveW-1:0]                      starve_q, starve_d;
  logic                                    w_ena_q, w_ena_d;
  logic [RegAddrW-1:0]                     w_addr_q, w_addr_d;
  logic [DATA_W-1:0]                       w_data_q, w_data_d;

  wb_fifo #(
    .Width (EntryW),
    .Depth (LSU_DEPTH)
  ) u_fifo (
    .clk_i         (clk),
    .rst_i         (rst),
    .push_i        (push),
    .push_data_i   ({lsu_wdata, lsu_rd}),
    .pop_i         (pop),
    .head_o        (fifo_head),
    .count_o       (fifo_count),
    .entry_valid_o (entry_valid),
    .entry_rd_o    (entry_rd)
  );

  // Handshakes look only at registered state, so a full FIFO never passes through.
  assign fifo_empty = (fifo_count == '0);
  assign force_ex   = (starve_q == StarveW'(STARVE_MAX));
  assign lsu_ready  = !rst && (fifo_count < CntW'(LSU_DEPTH));
  assign ex_ready   = !rst && (force_ex || fifo_empty);
  assign ex_fire    = ex_valid && ex_ready;
  assign push       = lsu_valid && lsu_ready;
  assign pop        = !rst && !ex_fire && !fifo_empty;

  always_comb begin
    starve_d = starve_q;
    w_ena_d  = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    if (ex_fire || !ex_valid) begin
      starve_d = '0;
    end else if (pop) begin
      starve_d = starve_q + StarveW'(1);
    end
    if (ex_fire) begin
      w_ena_d  = ex_wen && (ex_rd != '0);
      w_addr_d = ex_rd;
      w_data_d = ex_wdata;
    end else if (pop) begin
      w_ena_d  = (fifo_head[RegAddrW-1:0] != '0);
      w_addr_d = fifo_head[RegAddrW-1:0];
      w_data_d = fifo_head[EntryW-1:RegAddrW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      w_ena_q  <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= DATA_W'(ZeroWord);
    end else begin
      starve_q <= starve_d;
      w_ena_q  <= w_ena_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
    end
  end

  always_comb begin
    busy_mask = w_ena_q ? rd_mask(w_addr_q) : '0;
    for (int i = 0; i < LSU_DEPTH; i++) begin
      if (entry_valid[i]) busy_mask = busy_mask | rd_mask(entry_rd[i]);
    end
  end

  assign w_ena  = w_ena_q;
  assign w_addr = w_addr_q;
  assign w_data = w_data_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a vector table for single-cycle behaviour plus
// hand-written starvation and mid-operation reset sequences.
module tb_wb_stage;

  localparam int unsigned DW = 64;
  localparam int NV = 15;

  typedef struct {
    logic          ev, ewen;
    logic [4:0]    erd;
    logic [DW-1:0] edat;
    logic          lv;
    logic [4:0]    lrd;
    logic [DW-1:0] ldat;
    logic          x_exr, x_lsr, x_wena;
    logic [4:0]    x_waddr;
    logic [DW-1:0] x_wdata;
    logic [31:0]   x_busy;
  } vec_t;

  logic          clk, rst;
  logic          ex_valid, ex_wen, ex_ready, lsu_valid, lsu_ready, w_ena;
  logic [4:0]    ex_rd, lsu_rd, w_addr;
  logic [DW-1:0] ex_wdata, lsu_wdata, w_data;
  logic [31:0]   busy_mask;

  int checks = 0;
  int errors = 0;
  vec_t vecs [NV];

  wb_stage #(
    .DATA_W     (DW),
    .LSU_DEPTH  (2),
    .STARVE_MAX (4)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .ex_valid  (ex_valid),
    .ex_wen    (ex_wen),
    .ex_rd     (ex_rd),
    .ex_wdata  (ex_wdata),
    .ex_ready  (ex_ready),
    .lsu_valid (lsu_valid),
    .lsu_rd    (lsu_rd),
    .lsu_wdata (lsu_wdata),
    .lsu_ready (lsu_ready),
    .w_ena     (w_ena),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .busy_mask (busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(int ev, int ewen, int erd, longint edat, int lv, int lrd,
                              longint ldat, int xer, int xlr, int xwe, int xwa,
                              longint xwd, longint xb);
    vec_t v;
    v.ev = 1'(ev);         v.ewen = 1'(ewen);     v.erd = 5'(erd);
    v.edat = 64'(edat);    v.lv = 1'(lv);         v.lrd = 5'(lrd);
    v.ldat = 64'(ldat);    v.x_exr = 1'(xer);     v.x_lsr = 1'(xlr);
    v.x_wena = 1'(xwe);    v.x_waddr = 5'(xwa);   v.x_wdata = 64'(xwd);
    v.x_busy = 32'(xb);
    return v;
  endfunction

  function automatic logic [DW-1:0] ldat_of(int rd);
    return 64'(rd * 'h100 + 'h5);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    ex_valid = 1'b0; ex_wen = 1'b0; ex_rd = '0; ex_wdata = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_wdata = '0;
  endtask

  // Prime one entry, then hold EX while the LSU streams: EX must win after 4 pops,
  // leaving the FIFO full. Then either drain it or reset with both entries buffered.
  task automatic starve_run(input bit do_reset);
    drive_idle();
    lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_wdata = ldat_of(10);
    step();
    for (int k = 1; k <= 5; k++) begin
      ex_valid = 1'b1; ex_wen = 1'b1; ex_rd = 5'd20; ex_wdata = 64'hEEEE;
      lsu_valid = 1'b1; lsu_rd = 5'(10 + k); lsu_wdata = ldat_of(10 + k);
      check($sformatf("starve%0d_ex_ready", k), 64'(ex_ready), 64'(k == 5));
      check($sformatf("starve%0d_lsu_ready", k), 64'(lsu_ready), 64'd1);
      step();
      check($sformatf("starve%0d_w_ena", k), 64'(w_ena), 64'd1);
      check($sformatf("starve%0d_w_addr", k), 64'(w_addr), (k == 5) ? 64'd20 : 64'(9 + k));
      check($sformatf("starve%0d_w_data", k), w_data, (k == 5) ? 64'hEEEE : ldat_of(9 + k));
    end
    check("starve_busy_full", 64'(busy_mask), 64'((1 << 14) | (1 << 15) | (1 << 20)));
    if (!do_reset) begin
      drive_idle();
      lsu_valid = 1'b1; lsu_rd = 5'd16; lsu_wdata = ldat_of(16);
      check("full_lsu_ready", 64'(lsu_ready), 64'd0);
      check("full_ex_ready", 64'(ex_ready), 64'd0);
      step();
      check("drain0_w_addr", 64'(w_addr), 64'd14);
      check("drain0_w_data", w_data, ldat_of(14));
      check("drain0_busy", 64'(busy_mask), 64'((1 << 14) | (1 << 15)));
      drive_idle();
      check("drain1_lsu_ready", 64'(lsu_ready), 64'd1);
      step();
      check("drain1_w_ena", 64'(w_ena), 64'd1);
      check("drain1_w_addr", 64'(w_addr), 64'd15);
      check("drain1_w_data", w_data, ldat_of(15));
      step();
      check("drained_w_ena", 64'(w_ena), 64'd0);
      check("drained_busy", 64'(busy_mask), 64'd0);
      check("drained_ex_ready", 64'(ex_ready), 64'd1);
    end else begin
      drive_idle();
      rst = 1'b1;
      #1;
      check("inrst_ex_ready", 64'(ex_ready), 64'd0);
      check("inrst_lsu_ready", 64'(lsu_ready), 64'd0);
      step();
      rst = 1'b0;
      #1;
      check("postrst_w_ena", 64'(w_ena), 64'd0);
      check("postrst_w_addr", 64'(w_addr), 64'd0);
      check("postrst_w_data", w_data, 64'd0);
      check("postrst_busy", 64'(busy_mask), 64'd0);
      check("postrst_ex_ready", 64'(ex_ready), 64'd1);
      check("postrst_lsu_ready", 64'(lsu_ready), 64'd1);
      for (int c = 0; c < 3; c++) begin
        step();
        check($sformatf("postrst%0d_w_ena", c), 64'(w_ena), 64'd0);
        check($sformatf("postrst%0d_busy", c), 64'(busy_mask), 64'd0);
      end
    end
  endtask

  initial begin
    //                ev ew erd edat      lv lrd ldat     xer xlr xwe xwa xwdata    xbusy
    vecs[0]  = mk(1, 1, 5, 'h1234, 0, 0, 0,      1, 1, 1, 5, 'h1234, 'h20);
    vecs[1]  = mk(0, 0, 0, 0,      0, 0, 0,      1, 1, 0, 5, 'h1234, 'h0);
    vecs[2]  = mk(1, 1, 0, 'h55,   0, 0, 0,      1, 1, 0, 0, 'h55,   'h0);
    vecs[3]  = mk(1, 0, 9, 'h77,   0, 0, 0,      1, 1, 0, 9, 'h77,   'h0);
    vecs[4]  = mk(0, 0, 0, 0,      1, 7, 'hAA,   1, 1, 0, 9, 'h77,   'h80);
    vecs[5]  = mk(0, 0, 0, 0,      0, 0, 0,      0, 1, 1, 7, 'hAA,   'h80);
    vecs[6]  = mk(0, 0, 0, 0,      0, 0, 0,      1, 1, 0, 7, 'hAA,   'h0);
    vecs[7]  = mk(0, 0, 0, 0,      1, 1, 'h11,   1, 1, 0, 7, 'hAA,   'h2);
    vecs[8]  = mk(0, 0, 0, 0,      1, 2, 'h22,   0, 1, 1, 1, 'h11,   'h6);
    vecs[9]  = mk(0, 0, 0, 0,      0, 0, 0,      0, 1, 1, 2, 'h22,   'h4);
    vecs[10] = mk(0, 0, 0, 0,      1, 0, 'h33,   1, 1, 0, 2, 'h22,   'h0);
    vecs[11] = mk(0, 0, 0, 0,      0, 0, 0,      0, 1, 0, 0, 'h33,   'h0);
    vecs[12] = mk(1, 1, 3, 'h44,   1, 4, 'h66,   1, 1, 1, 3, 'h44,   'h18);
    vecs[13] = mk(0, 0, 0, 0,      0, 0, 0,      0, 1, 1, 4, 'h66,   'h10);
    vecs[14] = mk(0, 0, 0, 0,      0, 0, 0,      1, 1, 0, 4, 'h66,   'h0);

    drive_idle();
    rst = 1'b1;
    step();
    check("rst_ex_ready", 64'(ex_ready), 64'd0);
    check("rst_lsu_ready", 64'(lsu_ready), 64'd0);
    step();
    rst = 1'b0;
    #1;
    check("reset_w_ena", 64'(w_ena), 64'd0);
    check("reset_w_addr", 64'(w_addr), 64'd0);
    check("reset_w_data", w_data, 64'd0);
    check("reset_busy", 64'(busy_mask), 64'd0);

    for (int i = 0; i < NV; i++) begin
      ex_valid = vecs[i].ev;  ex_wen = vecs[i].ewen;  ex_rd = vecs[i].erd;
      ex_wdata = vecs[i].edat;
      lsu_valid = vecs[i].lv; lsu_rd = vecs[i].lrd;   lsu_wdata = vecs[i].ldat;
      check($sformatf("v%0d_ex_ready", i), 64'(ex_ready), 64'(vecs[i].x_exr));
      check($sformatf("v%0d_lsu_ready", i), 64'(lsu_ready), 64'(vecs[i].x_lsr));
      step();
      check($sformatf("v%0d_w_ena", i), 64'(w_ena), 64'(vecs[i].x_wena));
      check($sformatf("v%0d_w_addr", i), 64'(w_addr), 64'(vecs[i].x_waddr));
      check($sformatf("v%0d_w_data", i), w_data, vecs[i].x_wdata);
      check($sformatf("v%0d_busy", i), 64'(busy_mask), 64'(vecs[i].x_busy));
    end

    starve_run(1'b0);
    starve_run(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
